// File: rtl/ns_arb_pkg.sv
// Shared arbiter types and the round-robin pick helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package ns_arb_pkg;

  // Widest requester vector the pick helper handles.
  localparam int unsigned MAX_REQ = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index width for an n-entry one-hot vector, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req scanning ptr, ptr+1, ... modulo n; one-hot result.
  // Bits at or above n are never set in the result.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input int unsigned       n,
                                                 input int unsigned       ptr);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int unsigned        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if ((k < n) && !found) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/ns_1hot2bin.sv
// One-hot to binary encoder; all-zero input encodes to 0.
// Latency: combinational.
// Backpressure: none.
module ns_1hot2bin #(
  parameter  int ONE_HOT_WIDTH = 4,
  localparam int BIN_WIDTH     = (ONE_HOT_WIDTH > 1) ? $clog2(ONE_HOT_WIDTH) : 1
) (
  input  logic [ONE_HOT_WIDTH-1:0] one_hot,
  output logic [BIN_WIDTH-1:0]     bin
);

  // OR together the indices of set bits; exact for zero- or one-hot input.
  always_comb begin
    bin = '0;
    for (int i = 0; i < ONE_HOT_WIDTH; i++) begin
      if (one_hot[i]) bin = bin | BIN_WIDTH'(i);
    end
  end

endmodule

// File: rtl/ns_rr_arbiter.sv
// Round-robin locked-grant arbiter with registered one-hot grant and binary owner index.
// Latency: request at edge k is granted at edge k+1; release hands over on the same edge.
// Backpressure: owner keeps the grant while its request stays high; optional preemption
// after HOLD_MAX contended cycles when built with NS_ARB_PREEMPT_EN.
module ns_rr_arbiter
  import ns_arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int HOLD_MAX = 16,
  localparam int IDX_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             preempt_o
);

  arb_state_e         state_q;
  logic [N_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]   ptr_q;

  logic [N_REQ-1:0]   cand_mask;
  logic [MAX_REQ-1:0] pick_full;
  logic [N_REQ-1:0]   pick;
  logic [IDX_W-1:0]   pick_ptr;
  logic               pick_hi_unused;
  logic               owner_held;
  logic               others_wait;
  logic               preempt_hit;

  assign owner_held  = |(req_i & grant_q);
  assign others_wait = |(req_i & ~grant_q);

`ifdef NS_ARB_PREEMPT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] hold_q;
  logic              preempt_q;
  logic              new_grant;

  // Revoke on the contended edge that would bring the count to HOLD_MAX.
  assign preempt_hit = (state_q == BUSY) && owner_held && others_wait &&
                       (hold_q == HOLD_W'(HOLD_MAX - 1));

  assign new_grant = ((state_q == IDLE) && (|pick)) ||
                     ((state_q == BUSY) && !owner_held && (|pick)) ||
                     preempt_hit;

  // Hold counter: restarts on every new grant, counts only contended owner cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= preempt_hit;
      if (new_grant) begin
        hold_q <= '0;
      end else if ((state_q == BUSY) && owner_held && others_wait) begin
        hold_q <= hold_q + HOLD_W'(1);
      end
    end
  end

  assign preempt_o = preempt_q;
`else
  assign preempt_hit = 1'b0;
  assign preempt_o   = 1'b0;
`endif

  // Candidate set: a preempted owner sits out the re-arbitration edge.
  always_comb begin
    cand_mask = req_i;
    if (preempt_hit) cand_mask = req_i & ~grant_q;
  end

  assign pick_full      = rr_pick(MAX_REQ'(cand_mask), N_REQ, 32'(ptr_q));
  assign pick           = pick_full[N_REQ-1:0];
  assign pick_hi_unused = |pick_full;

  // Pointer moves to the slot just after the winner, wrapping at N_REQ.
  always_comb begin
    pick_ptr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_ptr = (i == N_REQ - 1) ? '0 : IDX_W'(i + 1);
    end
  end

  // Arbitration FSM: lock the grant until release (or preemption), hand over with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pick) begin
            grant_q <= pick;
            ptr_q   <= pick_ptr;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_held || preempt_hit) begin
            if (|pick) begin
              grant_q <= pick;
              ptr_q   <= pick_ptr;
            end else begin
              grant_q <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = |grant_q;

  ns_1hot2bin #(
    .ONE_HOT_WIDTH(N_REQ)
  ) u_idx_enc (
    .one_hot(grant_q),
    .bin    (grant_idx_o)
  );

  // Grant is never more than one-hot.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

  // Parameter legality.
  a_param_legal : assert property (@(posedge clk)
    (N_REQ >= 2) && (N_REQ <= int'(MAX_REQ)) && (HOLD_MAX >= 1));

endmodule

// File: tb/tb_ns_rr_arbiter.sv
module tb_ns_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req4;
  logic [3:0] grant4;
  logic       vld4;
  logic [1:0] idx4;
  logic       pre4;
  logic [2:0] req3;
  logic [2:0] grant3;
  logic       vld3;
  logic [1:0] idx3;
  logic       pre3;

  int total = 0;
  int bad   = 0;

  ns_rr_arbiter #(.N_REQ(4), .HOLD_MAX(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req4),
    .grant_o      (grant4),
    .grant_valid_o(vld4),
    .grant_idx_o  (idx4),
    .preempt_o    (pre4)
  );

  ns_rr_arbiter #(.N_REQ(3), .HOLD_MAX(4)) dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req3),
    .grant_o      (grant3),
    .grant_valid_o(vld3),
    .grant_idx_o  (idx3),
    .preempt_o    (pre3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] g, input logic [1:0] i);
    check({tag, ".grant"}, 32'(grant4), 32'(g));
    check({tag, ".idx"},   32'(idx4),   32'(i));
    check({tag, ".vld"},   32'(vld4),   32'(|g));
  endtask

  int owners [6] = '{3, 0, 1, 2, 3, 0};

  initial begin
    logic [3:0] oh;
    rst_n = 1'b0;
    req4  = 4'b0000;
    req3  = 3'b000;
    #12;
    chk4("reset", 4'b0000, 2'd0);
    check("reset.pre4",   32'(pre4),   32'(0));
    check("reset.grant3", 32'(grant3), 32'(0));
    check("reset.pre3",   32'(pre3),   32'(0));
    #11;
    rst_n = 1'b1;
    step();
    chk4("idle", 4'b0000, 2'd0);

    // single request, lock held
    req4 = 4'b0100;
    step();
    chk4("single", 4'b0100, 2'd2);
    for (int k = 0; k < 5; k++) begin
      step();
      chk4("single_hold", 4'b0100, 2'd2);
    end
    req4 = 4'b0000;
    step();
    chk4("single_rel", 4'b0000, 2'd0);

    // rotation starting at ptr=3, zero-bubble handover
    req4 = 4'b1111;
    step();
    for (int k = 0; k < 6; k++) begin
      oh = 4'b0001 << owners[k];
      chk4("rot", oh, 2'(owners[k]));
      step();
      chk4("rot_hold", oh, 2'(owners[k]));
      req4 = 4'b1111 & ~oh;
      step();
      req4 = 4'b1111;
    end
    chk4("rot_last", 4'b0010, 2'd1);
    req4 = 4'b0000;
    step();
    chk4("rot_idle", 4'b0000, 2'd0);

    // N_REQ=3 wrap from ptr=2
    req3 = 3'b010;
    step();
    check("n3.first", 32'(grant3), 32'(3'b010));
    req3 = 3'b000;
    step();
    check("n3.idle", 32'(grant3), 32'(0));
    req3 = 3'b011;
    step();
    check("n3.wrap_grant", 32'(grant3), 32'(3'b001));
    check("n3.wrap_idx",   32'(idx3),   32'(0));
    check("n3.wrap_vld",   32'(vld3),   32'(1));
    req3 = 3'b000;
    step();
    check("n3.rel_grant", 32'(grant3), 32'(0));
    check("n3.rel_vld",   32'(vld3),   32'(0));

    // owner releases while 1 requests; owner re-requests and waits (ptr=2 here)
    req4 = 4'b0001;
    step();
    chk4("req_own0", 4'b0001, 2'd0);
    req4 = 4'b0010;
    step();
    chk4("handover1", 4'b0010, 2'd1);
    req4 = 4'b0011;
    step();
    chk4("lock1", 4'b0010, 2'd1);
    step();
    chk4("lock1b", 4'b0010, 2'd1);
    req4 = 4'b0001;
    step();
    chk4("back0", 4'b0001, 2'd0);
    req4 = 4'b0000;
    step();
    chk4("back0_idle", 4'b0000, 2'd0);

    // contention on a held grant (ptr=1)
    req4 = 4'b0001;
    step();
    chk4("hold0", 4'b0001, 2'd0);
    req4 = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      step();
      chk4("wait", 4'b0001, 2'd0);
      check("wait.pre", 32'(pre4), 32'(0));
    end
    step();
`ifdef NS_ARB_PREEMPT_EN
    chk4("preempt", 4'b0100, 2'd2);
    check("preempt.pulse", 32'(pre4), 32'(1));
    step();
    chk4("preempt_after", 4'b0100, 2'd2);
    check("preempt.once", 32'(pre4), 32'(0));
`else
    chk4("no_preempt", 4'b0001, 2'd0);
    check("no_preempt.pre", 32'(pre4), 32'(0));
    for (int k = 0; k < 10; k++) begin
      step();
      check("unbounded.grant", 32'(grant4), 32'(4'b0001));
      check("unbounded.pre",   32'(pre4),   32'(0));
    end
`endif
    req4 = 4'b0000;
    step();
    chk4("cont_idle", 4'b0000, 2'd0);

    // asynchronous reset in BUSY
    req4 = 4'b0010;
    step();
    chk4("pre_rst", 4'b0010, 2'd1);
    #2;
    rst_n = 1'b0;
    req4  = 4'b0000;
    #1;
    chk4("async_rst", 4'b0000, 2'd0);
    #2;
    rst_n = 1'b1;
    req4  = 4'b1000;
    step();
    chk4("post_rst", 4'b1000, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
